// File: rtl/ddr_arb_pkg.sv
// Shared defaults and slot state encoding for the DDR client arbiter.
package ddr_arb_pkg;

    localparam int ADDR_W_DEF       = 24;
    localparam int DATA_W_DEF       = 16;
    localparam int STARVE_LIMIT_DEF = 8;

    // Hold-until-ack slot states; kept as plain constants so older tools accept them.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/arb_slot.sv
// One hold-until-ack channel: latches the granted owner/address/data, drives the
// Ddr request from those registers only, and routes the Ddr ack to the owner.
module arb_slot
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              i_grant_valid,
    input  logic              i_grant_owner,
    input  logic [ADDR_W-1:0] i_grant_addr,
    input  logic [DATA_W-1:0] i_grant_data,
    input  logic              i_ddr_ack,
    output logic              o_idle,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_client_ack
);

    logic [0:0]        r_state;
    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_done;

    // An ack only completes a transaction while one is outstanding; stray acks are dropped.
    assign w_done = (r_state == ST_BUSY) && i_ddr_ack;

    // IDLE latches a grant and raises the request next cycle; BUSY waits for the Ddr ack.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (r_state == ST_IDLE) begin
            if (i_grant_valid) begin
                r_state <= ST_BUSY;
                r_owner <= i_grant_owner;
                r_addr  <= i_grant_addr;
                r_data  <= i_grant_data;
            end
        end else if (i_ddr_ack) begin
            r_state <= ST_IDLE;
        end
    end

    assign o_idle = (r_state == ST_IDLE);
    assign o_req  = (r_state == ST_BUSY);
    assign o_addr = r_addr;
    assign o_data = r_data;

    // Per-client ack demux, combinational so the client sees it alongside the Ddr ack.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign o_client_ack[gi] = w_done && (r_owner == 1'(gi));
        end
    endgenerate

endmodule

// File: rtl/ddr_arbiter.sv
// Shares the Ddr read and write ports between two read and two write clients.
// Reads: display fetcher (client 0) has fixed priority with a starvation guard
// for the graphics engine; writes: round-robin between engine and host loader.
module ddr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk133_p,
    input  logic              rst,
    input  logic [1:0]        rdReq,
    input  logic [ADDR_W-1:0] rdAddr0,
    input  logic [ADDR_W-1:0] rdAddr1,
    output logic [1:0]        rdAck,
    output logic [DATA_W-1:0] rdData,
    input  logic [1:0]        wrReq,
    input  logic [ADDR_W-1:0] wrAddr0,
    input  logic [ADDR_W-1:0] wrAddr1,
    input  logic [DATA_W-1:0] wrData0,
    input  logic [DATA_W-1:0] wrData1,
    output logic [1:0]        wrAck,
    output logic              read,
    output logic [ADDR_W-1:0] readAddress,
    input  logic              readAcknowledge,
    input  logic [DATA_W-1:0] readData,
    output logic              write,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0] writeData,
    input  logic              writeAcknowledge
);

    // Wide enough to hold STARVE_LIMIT itself (and never zero bits wide).
    localparam int                  STREAK_W   = $clog2(STARVE_LIMIT + 2);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic                w_rd_idle;
    logic                w_rd_grant_valid;
    logic                w_rd_grant_owner;
    logic                w_rd_starved;
    logic [ADDR_W-1:0]   w_rd_grant_addr;
    logic [DATA_W-1:0]   w_rd_data_unused;
    logic [STREAK_W-1:0] r_streak;

    logic                w_wr_idle;
    logic                w_wr_grant_valid;
    logic                w_wr_grant_owner;
    logic [ADDR_W-1:0]   w_wr_grant_addr;
    logic [DATA_W-1:0]   w_wr_grant_data;
    logic                r_last_wr;

    // Read grant: client 0 wins unless client 1 has watched STARVE_LIMIT client-0 grants go by.
    always_comb begin
        w_rd_grant_valid = w_rd_idle && (rdReq != 2'b00);
        w_rd_starved     = rdReq[1] && (r_streak == STREAK_MAX);
        w_rd_grant_owner = rdReq[1] && (!rdReq[0] || w_rd_starved);
        w_rd_grant_addr  = w_rd_grant_owner ? rdAddr1 : rdAddr0;
    end

    // Streak counts client-0 grants made while client 1 waits; any other grant clears it.
    always_ff @(posedge clk133_p) begin
        if (rst) begin
            r_streak <= '0;
        end else if (w_rd_grant_valid) begin
            if (!w_rd_grant_owner && rdReq[1]) begin
                r_streak <= (r_streak == STREAK_MAX) ? STREAK_MAX : r_streak + 1'b1;
            end else begin
                r_streak <= '0;
            end
        end
    end

    // Write grant: a lone requester wins; on a tie the client not served last wins.
    always_comb begin
        w_wr_grant_valid = w_wr_idle && (wrReq != 2'b00);
        w_wr_grant_owner = (wrReq == 2'b11) ? ~r_last_wr : wrReq[1];
        w_wr_grant_addr  = w_wr_grant_owner ? wrAddr1 : wrAddr0;
        w_wr_grant_data  = w_wr_grant_owner ? wrData1 : wrData0;
    end

    // Remember the last write owner; reset to 1 so client 0 takes the first tie.
    always_ff @(posedge clk133_p) begin
        if (rst) begin
            r_last_wr <= 1'b1;
        end else if (w_wr_grant_valid) begin
            r_last_wr <= w_wr_grant_owner;
        end
    end

    // Read data is never buffered; both read clients see the Ddr bus directly.
    assign rdData = readData;

    arb_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_slot (
        .clk           (clk133_p),
        .srst          (rst),
        .i_grant_valid (w_rd_grant_valid),
        .i_grant_owner (w_rd_grant_owner),
        .i_grant_addr  (w_rd_grant_addr),
        .i_grant_data  ({DATA_W{1'b0}}),
        .i_ddr_ack     (readAcknowledge),
        .o_idle        (w_rd_idle),
        .o_req         (read),
        .o_addr        (readAddress),
        .o_data        (w_rd_data_unused),
        .o_client_ack  (rdAck)
    );

    arb_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_slot (
        .clk           (clk133_p),
        .srst          (rst),
        .i_grant_valid (w_wr_grant_valid),
        .i_grant_owner (w_wr_grant_owner),
        .i_grant_addr  (w_wr_grant_addr),
        .i_grant_data  (w_wr_grant_data),
        .i_ddr_ack     (writeAcknowledge),
        .o_idle        (w_wr_idle),
        .o_req         (write),
        .o_addr        (writeAddress),
        .o_data        (writeData),
        .o_client_ack  (wrAck)
    );

endmodule
